// File: rtl/config_stream_encoder.sv
// Encodes a 32-bit target configuration into nibble-write commands for the config register,
// tracking a shadow of what has been committed and ending each non-empty burst with a flush duplicate.
module config_stream_encoder #(
    parameter logic [31:0] DEFAULT_CFG = 32'hBBFC_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        full_mode,
    input  logic [31:0] cfg_target,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] shadow_cfg
);

    typedef enum logic [2:0] {IDLE, SCAN, SEND, FLUSH, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] tgt, tgt_nx;
    logic        fm, fm_nx;
    logic [2:0]  idx, idx_nx;
    logic        sent, sent_nx;
    logic [7:0]  last, last_nx;
    logic [31:0] shadow_nx;
    logic [7:0]  cmd_byte_nx;
    logic        cmd_valid_nx;

    logic [3:0]  tgt_nib;
    logic        hit;

    assign tgt_nib = tgt[{idx, 2'b00} +: 4];
    assign hit     = fm || (tgt_nib != shadow_cfg[{idx, 2'b00} +: 4]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tgt        <= '0;
            fm         <= 1'b0;
            idx        <= '0;
            sent       <= 1'b0;
            last       <= '0;
            shadow_cfg <= DEFAULT_CFG;
            cmd_byte   <= '0;
            cmd_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            tgt        <= tgt_nx;
            fm         <= fm_nx;
            idx        <= idx_nx;
            sent       <= sent_nx;
            last       <= last_nx;
            shadow_cfg <= shadow_nx;
            cmd_byte   <= cmd_byte_nx;
            cmd_valid  <= cmd_valid_nx;
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = SCAN;
            SCAN: begin
                if (hit)               state_nx = SEND;
                else if (idx == 3'd7)  state_nx = sent ? FLUSH : DONE;
            end
            SEND:  if (cmd_ready) state_nx = (idx == 3'd7) ? FLUSH : SCAN;
            FLUSH: if (cmd_ready) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs are computed here one cycle ahead so nothing downstream sees a comb path.
    always_comb begin
        tgt_nx       = tgt;
        fm_nx        = fm;
        idx_nx       = idx;
        sent_nx      = sent;
        last_nx      = last;
        shadow_nx    = shadow_cfg;
        cmd_byte_nx  = cmd_byte;
        cmd_valid_nx = cmd_valid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    tgt_nx  = cfg_target;
                    fm_nx   = full_mode;
                    idx_nx  = '0;
                    sent_nx = 1'b0;
                end
            end
            SCAN: begin
                if (hit) begin
                    cmd_byte_nx  = {1'b0, idx, tgt_nib};
                    cmd_valid_nx = 1'b1;
                end else if (idx == 3'd7) begin
                    if (sent) begin
                        cmd_byte_nx  = last;
                        cmd_valid_nx = 1'b1;
                    end
                end else begin
                    idx_nx = idx + 3'd1;
                end
            end
            SEND: begin
                if (cmd_ready) begin
                    shadow_nx[{cmd_byte[6:4], 2'b00} +: 4] = cmd_byte[3:0];
                    last_nx = cmd_byte;
                    sent_nx = 1'b1;
                    if (idx == 3'd7) begin
                        cmd_byte_nx  = cmd_byte;
                        cmd_valid_nx = 1'b1;
                    end else begin
                        idx_nx       = idx + 3'd1;
                        cmd_valid_nx = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (cmd_ready) cmd_valid_nx = 1'b0;
            end
            DONE: ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_config_stream_encoder.sv
// Directed bench for config_stream_encoder: byte sequences, done timing, back-pressure, restart and reset.
module tb_config_stream_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        full_mode;
    logic [31:0] cfg_target;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [31:0] shadow_cfg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    config_stream_encoder #(.DEFAULT_CFG(32'hBBFC_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .full_mode  (full_mode),
        .cfg_target (cfg_target),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done),
        .shadow_cfg (shadow_cfg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request from the cycle-0 start and checks the accepted bytes against exp_q.
    task automatic run_req(input string name, input logic [31:0] cfg, input logic fmode,
                           input bit toggle, input int restart_at,
                           input int exp_done, input logic [31:0] exp_shadow);
        logic [7:0] got[$];
        int   done_cyc   = -1;
        logic prev_stall = 1'b0;
        logic [7:0] prev_byte = '0;
        logic any_valid  = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        cfg_target = cfg;
        full_mode  = fmode;
        cmd_ready  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("%s_busy_c1", name), 32'(busy), 32'd1);
                cfg_target = ~cfg;
                full_mode  = ~fmode;
            end
            start     = (c == restart_at);
            cmd_ready = toggle ? (c % 2 == 1) : 1'b1;
            if (prev_stall) check($sformatf("%s_stable_c%0d", name, c), 32'(cmd_byte), 32'(prev_byte));
            if (cmd_valid) any_valid = 1'b1;
            if (cmd_valid && cmd_ready) got.push_back(cmd_byte);
            prev_stall = cmd_valid && !cmd_ready;
            prev_byte  = cmd_byte;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start     = 1'b0;
        cmd_ready = 1'b1;
        check($sformatf("%s_done_cycle", name), 32'(done_cyc), 32'(exp_done));
        check($sformatf("%s_nbytes", name), 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
        if (exp_q.size() == 0) check($sformatf("%s_no_valid", name), 32'(any_valid), 32'd0);
        @(negedge clk);
        check($sformatf("%s_done_1cyc", name), 32'(done), 32'd0);
        check($sformatf("%s_busy_low", name), 32'(busy), 32'd0);
        check($sformatf("%s_shadow", name), shadow_cfg, exp_shadow);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        full_mode  = 1'b0;
        cfg_target = '0;
        cmd_ready  = 1'b1;
        #1;
        check("rst_cmd_byte",  32'(cmd_byte),  32'h00);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_shadow",    shadow_cfg,     32'hBBFC_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        exp_q = '{8'h08, 8'h17, 8'h26, 8'h35, 8'h44, 8'h53, 8'h62, 8'h71, 8'h71};
        run_req("full", 32'h1234_5678, 1'b1, 1'b0, 0, 18, 32'h1234_5678);

        do_reset();
        exp_q = '{8'h1A, 8'h1A};
        run_req("diff1", 32'hBBFC_00A0, 1'b0, 1'b0, 0, 11, 32'hBBFC_00A0);

        exp_q = {};
        run_req("diff0", 32'hBBFC_00A0, 1'b0, 1'b0, 0, 9, 32'hBBFC_00A0);

        // ready high on odd cycles: byte 0 and the flush each stall once
        exp_q = '{8'h08, 8'h17, 8'h26, 8'h35, 8'h44, 8'h53, 8'h62, 8'h71, 8'h71};
        run_req("toggle", 32'h1234_5678, 1'b1, 1'b1, 0, 20, 32'h1234_5678);

        exp_q = '{8'h0D, 8'h10, 8'h20, 8'h3F, 8'h4E, 8'h5F, 8'h6A, 8'h7C, 8'h7C};
        run_req("restart", 32'hCAFE_F00D, 1'b1, 1'b0, 3, 18, 32'hCAFE_F00D);

        exp_q = '{8'h00, 8'h30, 8'h30};
        run_req("diff2", 32'hCAFE_0000, 1'b0, 1'b0, 0, 12, 32'hCAFE_0000);

        // Reset while byte 3 waits on a stalled downstream.
        @(negedge clk);
        start      = 1'b1;
        cfg_target = 32'h1234_5678;
        full_mode  = 1'b1;
        cmd_ready  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 7) cmd_ready = 1'b0;
        end
        @(negedge clk);
        check("mid_valid",  32'(cmd_valid), 32'd1);
        check("mid_byte",   32'(cmd_byte),  32'h35);
        check("mid_shadow", shadow_cfg,     32'hCAFE_0678);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",  32'(cmd_valid), 32'd0);
        check("arst_busy",   32'(busy),      32'd0);
        check("arst_done",   32'(done),      32'd0);
        check("arst_shadow", shadow_cfg,     32'hBBFC_0000);
        @(negedge clk);
        rst       = 1'b0;
        cmd_ready = 1'b1;
        exp_q = '{8'h08, 8'h17, 8'h26, 8'h35, 8'h44, 8'h53, 8'h62, 8'h71, 8'h71};
        run_req("post_rst", 32'h1234_5678, 1'b1, 1'b0, 0, 18, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
